// File: rtl/storage_ctrl_pkg.sv
// storage_ctrl_pkg: shared types, defaults and helpers for storage_ctrl_v2.
package storage_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRAM_RD,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_EXT_REQ,
    ST_EXT_WAIT,
    ST_RESP,
    ST_PROG
  } state_e;

  // Where the response data comes from while in RESP
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_SRAM,
    SRC_EXT
  } rsp_src_e;

  // First byte address that no longer maps to the on-chip SRAM
  localparam logic [31:0] SRAM_LIMIT_DEF = 32'h0000_2000;

  // Byte-lane merge: enabled lanes from new_w, the rest from old_w
  function automatic logic [31:0] merge_bytes(input logic [31:0] new_w,
                                              input logic [31:0] old_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/storage_ctrl_v2_ext_port.sv
// storage_ext_port: wishbone strobe/stall/ack handshake towards the SPI flash
// engine, read-data capture, and the optional access timeout.
// Optional feature macro: STORAGE_CTRL_V2_TIMEOUT_EN (adds the timeout counter).
module storage_ext_port #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_i,
  input  logic        in_wait_i,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_rdata_i,
  output logic        wb_stb_o,
  output logic        issued_o,
  output logic        acked_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_q, rdata_d;

  // Strobe follows the controller state directly, so it is state-driven only
  assign wb_stb_o = in_req_i;
  assign issued_o = in_req_i && !wb_stall_i;
  assign acked_o  = in_wait_i && wb_ack_i;
  assign rdata_o  = rdata_q;

  // Hold the last acknowledged read word for the response cycle
  always_comb begin
    rdata_d = rdata_q;
    if (acked_o) rdata_d = wb_rdata_i;
  end

  // Read-data register
  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

`ifdef STORAGE_CTRL_V2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy;

  assign busy = in_req_i || in_wait_i;

  // Count cycles spent in the external phases; restart whenever idle
  always_comb begin
    cnt_d = '0;
    if (busy) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Last allowed cycle: the controller leaves for RESP on the next edge
  assign timeout_o = busy && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/storage_ctrl_v2.sv
// storage_ctrl_v2: request front end for on-chip SRAM (with byte-enable
// read-modify-write) and external SPI flash via a wishbone engine, plus a
// programming-mode pad mux. Optional macro STORAGE_CTRL_V2_TIMEOUT_EN enables
// the external-access timeout.
module storage_ctrl_v2
  import storage_ctrl_pkg::*;
#(
  parameter int          SRAM_AW     = 11,
  parameter logic [31:0] SRAM_LIMIT  = SRAM_LIMIT_DEF,
  parameter int          EXT_AW      = 22,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  input  logic               prog_set,
  input  logic               prog_clr,
  output logic               prog_active,
  output logic               sram_cen_n,
  output logic               sram_wen_n,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [31:0]        sram_d,
  input  logic [31:0]        sram_q,
  output logic               wb_stb,
  output logic               wb_we,
  output logic [EXT_AW-1:0]  wb_addr,
  input  logic               wb_stall,
  input  logic               wb_ack,
  input  logic [31:0]        wb_rdata,
  output logic               ext_cs_n,
  output logic               ext_sck,
  output logic               ext_mosi,
  input  logic               ext_miso,
  input  logic               pgm_cs_n,
  input  logic               pgm_sck,
  input  logic               pgm_mosi,
  output logic               pgm_miso,
  input  logic               eng_cs_n,
  input  logic               eng_sck,
  input  logic               eng_mosi,
  output logic               eng_miso
);

  state_e            state_q, state_d;
  rsp_src_e          src_q, src_d;
  logic [EXT_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;
  logic              prog_pend_q, prog_pend_d;

  logic              ext_issued, ext_acked, ext_timeout;
  logic [31:0]       ext_rdata;

  storage_ext_port #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ext_port (
    .clk        (clk),
    .rst        (rst),
    .in_req_i   (state_q == ST_EXT_REQ),
    .in_wait_i  (state_q == ST_EXT_WAIT),
    .wb_stall_i (wb_stall),
    .wb_ack_i   (wb_ack),
    .wb_rdata_i (wb_rdata),
    .wb_stb_o   (wb_stb),
    .issued_o   (ext_issued),
    .acked_o    (ext_acked),
    .timeout_o  (ext_timeout),
    .rdata_o    (ext_rdata)
  );

  // Next-state logic; prog_set is remembered so an in-flight access finishes first
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_d       = err_q;
    prog_pend_d = prog_pend_q | prog_set;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[EXT_AW-1:0];
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = 1'b0;
          src_d   = SRC_ZERO;
          if (req_addr < SRAM_LIMIT) begin
            if (!req_we)               state_d = ST_SRAM_RD;
            else if (req_be == 4'hF)   state_d = ST_RMW_WR;
            else if (req_be == 4'h0)   state_d = ST_RESP;
            else                       state_d = ST_RMW_RD;
          end else if (req_we) begin
            // Flash is read-only through this path
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_EXT_REQ;
          end
        end else if (prog_pend_q || prog_set) begin
          prog_pend_d = 1'b0;
          state_d     = ST_PROG;
        end
      end
      ST_SRAM_RD: begin
        src_d   = SRC_SRAM;
        state_d = ST_RESP;
      end
      ST_RMW_RD:  state_d = ST_RMW_WR;
      ST_RMW_WR:  state_d = ST_RESP;
      ST_EXT_REQ: begin
        if (ext_timeout) begin
          err_d   = 1'b1;
          src_d   = SRC_ZERO;
          state_d = ST_RESP;
        end else if (ext_issued) begin
          state_d = ST_EXT_WAIT;
        end
      end
      ST_EXT_WAIT: begin
        if (ext_acked) begin
          src_d   = SRC_EXT;
          state_d = ST_RESP;
        end else if (ext_timeout) begin
          err_d   = 1'b1;
          src_d   = SRC_ZERO;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (prog_pend_q || prog_set) begin
          prog_pend_d = 1'b0;
          state_d     = ST_PROG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROG: begin
        prog_pend_d = 1'b0;
        if (prog_clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_ZERO;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      prog_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_q       <= err_d;
      prog_pend_q <= prog_pend_d;
    end
  end

  // Handshake and response outputs decoded from registered state
  always_comb begin
    req_ready = rst && (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = (state_q == ST_RESP) && err_q;
    rsp_rdata = '0;
    if (state_q == ST_RESP) begin
      case (src_q)
        SRC_SRAM: rsp_rdata = sram_q;
        SRC_EXT:  rsp_rdata = ext_rdata;
        default:  rsp_rdata = '0;
      endcase
    end
    prog_active = (state_q == ST_PROG);
  end

  // SRAM strobes; the merged word is written in one cycle so a reset never splits it
  always_comb begin
    sram_cen_n = !((state_q == ST_SRAM_RD) || (state_q == ST_RMW_RD) ||
                   (state_q == ST_RMW_WR));
    sram_wen_n = (state_q != ST_RMW_WR);
    sram_a     = addr_q[SRAM_AW+1:2];
    sram_d     = merge_bytes(wdata_q, sram_q, be_q);
    wb_we      = 1'b0;
    wb_addr    = addr_q;
  end

  // SPI pad ownership: programming pins in PROG, the flash engine otherwise
  always_comb begin
    ext_cs_n = prog_active ? pgm_cs_n : eng_cs_n;
    ext_sck  = prog_active ? pgm_sck  : eng_sck;
    ext_mosi = prog_active ? pgm_mosi : eng_mosi;
    pgm_miso = prog_active ? ext_miso : 1'b0;
    eng_miso = prog_active ? 1'b0     : ext_miso;
  end

endmodule

// File: tb/tb_storage_ctrl_v2.sv
// tb_storage_ctrl_v2: directed, table-driven bench for storage_ctrl_v2 with a
// behavioural SRAM and a hand-driven wishbone engine.
module tb_storage_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        prog_set, prog_clr, prog_active;
  logic        sram_cen_n, sram_wen_n;
  logic [10:0] sram_a;
  logic [31:0] sram_d, sram_q;
  logic        wb_stb, wb_we, wb_stall, wb_ack;
  logic [21:0] wb_addr;
  logic [31:0] wb_rdata;
  logic        ext_cs_n, ext_sck, ext_mosi, ext_miso;
  logic        pgm_cs_n, pgm_sck, pgm_mosi, pgm_miso;
  logic        eng_cs_n, eng_sck, eng_mosi, eng_miso;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cycles = 0;

  storage_ctrl_v2 #(
    .SRAM_AW     (11),
    .SRAM_LIMIT  (32'h0000_2000),
    .EXT_AW      (22),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .prog_set(prog_set), .prog_clr(prog_clr), .prog_active(prog_active),
    .sram_cen_n(sram_cen_n), .sram_wen_n(sram_wen_n), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr), .wb_stall(wb_stall),
    .wb_ack(wb_ack), .wb_rdata(wb_rdata),
    .ext_cs_n(ext_cs_n), .ext_sck(ext_sck), .ext_mosi(ext_mosi), .ext_miso(ext_miso),
    .pgm_cs_n(pgm_cs_n), .pgm_sck(pgm_sck), .pgm_mosi(pgm_mosi), .pgm_miso(pgm_miso),
    .eng_cs_n(eng_cs_n), .eng_sck(eng_sck), .eng_mosi(eng_mosi), .eng_miso(eng_miso)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with one-cycle registered read
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (!sram_cen_n) begin
      if (!sram_wen_n) mem[sram_a] <= sram_d;
      else             sram_q      <= mem[sram_a];
    end
  end

  always @(posedge clk) if (wb_stb === 1'b1) stb_cycles <= stb_cycles + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request; latency counts clock edges from accept to the first rsp_valid cycle
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic err,
                     output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          k;

    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    sram_q = 32'h0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    prog_set = 1'b0; prog_clr = 1'b0; wb_stall = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    ext_miso = 1'b0; pgm_cs_n = 1'b1; pgm_sck = 1'b0; pgm_mosi = 1'b0;
    eng_cs_n = 1'b1; eng_sck = 1'b0; eng_mosi = 1'b0;

    //          we    addr          wdata         be    chk   exp_rdata     err  lat
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b0, 2};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 1'b0, 32'h0,        1'b0, 3};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEAA, 1'b0, 2};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h0055_0000, 4'h4, 1'b0, 32'h0,        1'b0, 3};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 32'hDE55_BEAA, 1'b0, 2};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,        1'b0, 1};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 32'hDE55_BEAA, 1'b0, 2};
    vecs[8]  = '{1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,        1'b0, 2};
    vecs[9]  = '{1'b0, 32'h0000_1FFC, 32'h0,         4'hF, 1'b1, 32'hCAFE_F00D, 1'b0, 2};
    vecs[10] = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'hA, 1'b0, 32'h0,        1'b0, 3};
    vecs[11] = '{1'b0, 32'h0000_0004, 32'h0,         4'hF, 1'b1, 32'h1100_3300, 1'b0, 2};
    vecs[12] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b1, 32'h0,        1'b1, 1};
    vecs[13] = '{1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 1'b1, 32'h0,        1'b1, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready",   {31'b0, req_ready},   32'h0);
    chk("rst_rsp_valid",   {31'b0, rsp_valid},   32'h0);
    chk("rst_rsp_err",     {31'b0, rsp_err},     32'h0);
    chk("rst_rsp_rdata",   rsp_rdata,            32'h0);
    chk("rst_wb_stb",      {31'b0, wb_stb},      32'h0);
    chk("rst_sram_cen_n",  {31'b0, sram_cen_n},  32'h1);
    chk("rst_sram_wen_n",  {31'b0, sram_wen_n},  32'h1);
    chk("rst_prog_active", {31'b0, prog_active}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'b0, req_ready}, 32'h1);

    // Table-driven SRAM and external-write transactions
    stb_cycles = 0;
    for (int i = 0; i < 14; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, err, lat);
      $display("txn %0d: we=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, err, lat);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    chk("no_wb_stb_in_table", stb_cycles, 0);

    // External read with 3 stalled strobe cycles and ack 5 cycles after issue
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2004; req_be = 4'hF; wb_stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ext_stb_up",   {31'b0, wb_stb}, 32'h1);
    chk("ext_wb_addr",  {10'b0, wb_addr}, 32'h0000_2004);
    chk("ext_wb_we",    {31'b0, wb_we},  32'h0);
    repeat (3) @(negedge clk);
    chk("ext_stb_held", {31'b0, wb_stb}, 32'h1);
    wb_stall = 1'b0;
    @(negedge clk);
    chk("ext_stb_drop", {31'b0, wb_stb}, 32'h0);
    repeat (4) @(negedge clk);
    wb_ack = 1'b1; wb_rdata = 32'h1234_5678;
    @(negedge clk);
    wb_ack = 1'b0; wb_rdata = 32'h0;
    $display("ext read 0x2004: rsp_valid=%0b rdata=%h err=%0b", rsp_valid, rsp_rdata, rsp_err);
    chk("ext_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("ext_rsp_rdata", rsp_rdata,          32'h1234_5678);
    chk("ext_rsp_err",   {31'b0, rsp_err},   32'h0);
    @(negedge clk);
    chk("ext_rsp_one_cycle", {31'b0, rsp_valid}, 32'h0);
    chk("ext_back_idle",     {31'b0, req_ready}, 32'h1);

    // prog_set during an external read: read finishes, then programming mode
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2008;
    @(negedge clk);
    req_valid = 1'b0; prog_set = 1'b1;
    @(negedge clk);
    chk("prog_not_yet", {31'b0, prog_active}, 32'h0);
    wb_ack = 1'b1; wb_rdata = 32'hA5A5_0001;
    @(negedge clk);
    wb_ack = 1'b0; wb_rdata = 32'h0;
    chk("prog_rd_valid", {31'b0, rsp_valid}, 32'h1);
    chk("prog_rd_rdata", rsp_rdata,          32'hA5A5_0001);
    @(negedge clk);
    prog_set = 1'b0;
    $display("prog entry: prog_active=%0b req_ready=%0b", prog_active, req_ready);
    chk("prog_active_on", {31'b0, prog_active}, 32'h1);
    chk("prog_not_ready", {31'b0, req_ready},   32'h0);
    pgm_sck = 1'b1; eng_sck = 1'b0; ext_miso = 1'b1; pgm_cs_n = 1'b0;
    #1;
    chk("prog_sck_pgm_hi", {31'b0, ext_sck},  32'h1);
    chk("prog_cs_pgm",     {31'b0, ext_cs_n}, 32'h0);
    chk("prog_pgm_miso",   {31'b0, pgm_miso}, 32'h1);
    chk("prog_eng_miso",   {31'b0, eng_miso}, 32'h0);
    pgm_sck = 1'b0; eng_sck = 1'b1;
    #1;
    chk("prog_sck_pgm_lo", {31'b0, ext_sck}, 32'h0);
    @(negedge clk);
    chk("prog_stays", {31'b0, prog_active}, 32'h1);
    prog_clr = 1'b1;
    @(negedge clk);
    prog_clr = 1'b0;
    $display("prog exit: prog_active=%0b req_ready=%0b", prog_active, req_ready);
    chk("prog_off",       {31'b0, prog_active}, 32'h0);
    chk("prog_off_ready", {31'b0, req_ready},   32'h1);
    #1;
    chk("idle_sck_eng",  {31'b0, ext_sck},  32'h1);
    chk("idle_pgm_miso", {31'b0, pgm_miso}, 32'h0);
    chk("idle_eng_miso", {31'b0, eng_miso}, 32'h1);
    ext_miso = 1'b0; pgm_cs_n = 1'b1;

    // prog_set and prog_clr together while in PROG: clr wins
    @(negedge clk);
    prog_set = 1'b1;
    @(negedge clk);
    chk("clrwin_enter", {31'b0, prog_active}, 32'h1);
    prog_clr = 1'b1;
    @(negedge clk);
    prog_set = 1'b0; prog_clr = 1'b0;
    chk("clrwin_exit", {31'b0, prog_active}, 32'h0);
    @(negedge clk);
    chk("clrwin_idle", {31'b0, req_ready}, 32'h1);

    // Reset in the middle of an external read abandons it silently
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_stb_up", {31'b0, wb_stb}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stb_off",   {31'b0, wb_stb},    32'h0);
    chk("midrst_no_rsp",    {31'b0, rsp_valid}, 32'h0);
    chk("midrst_not_ready", {31'b0, req_ready}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'b0, req_ready}, 32'h1);

`ifdef STORAGE_CTRL_V2_TIMEOUT_EN
    // External read never acknowledged: error response 16 cycles after strobe rises
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2020;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_stb_up", {31'b0, wb_stb}, 32'h1);
    k = 0;
    while (!rsp_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    $display("timeout read: cycles=%0d err=%0b rdata=%h", k, rsp_err, rsp_rdata);
    chk("to_cycles", k, 16);
    chk("to_err",    {31'b0, rsp_err}, 32'h1);
    chk("to_rdata",  rsp_rdata,        32'h0);
    wb_ack = 1'b1; wb_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    wb_ack = 1'b0;
    @(negedge clk);
    chk("to_stray_ack_ignored", {31'b0, rsp_valid}, 32'h0);
    chk("to_ready",             {31'b0, req_ready}, 32'h1);
`else
    k = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
